// File: rtl/m_stage.sv
// MIPS memory stage: X/M pipeline register, branch resolution, req/ack data-memory access, WB bundle.
// Optional ack-wait watchdog enabled by defining MEM_TIMEOUT_EN.
module m_stage #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       alu,
  input  logic [31:0]       rt,
  input  logic [4:0]        dst_addr,
  input  logic              zero,
  input  logic [31:0]       pc_branch,
  input  logic              branch,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              pcsrc,
  output logic [31:0]       branch_target,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_dst_addr,
  output logic [31:0]       wb_data,
  output logic              mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]       r_alu;
  logic [4:0]        r_dst;
  logic              r_m2r, r_rw, r_store;
  logic              r_req, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_pcsrc;
  logic [31:0]       r_target;
  logic              r_wb_valid, r_wb_rw;
  logic [4:0]        r_wb_dst;
  logic [31:0]       r_wb_data;
  logic              r_err;

  logic w_accept, w_memop, w_ack, w_timeout, w_unused_bits;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_memop  = mem_read | mem_write;
  assign w_ack    = (r_state == S_ACCESS) && mem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;

  // Counter sits at zero outside ACCESS, so it restarts for every access.
  always_ff @(posedge clk) begin
    if (!rst_n || r_state != S_ACCESS) r_cnt <= '0;
    else                               r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout     = (r_state == S_ACCESS) && !mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_unused_bits = ^alu[31:ADDR_W];
`else
  assign w_timeout     = 1'b0;
  assign w_unused_bits = ^{alu[31:ADDR_W], (TIMEOUT != 0)};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (in_valid && w_memop)    w_state_nxt = S_ACCESS;
      S_ACCESS: if (mem_ack || w_timeout)   w_state_nxt = S_RESP;
      S_RESP:                               w_state_nxt = S_IDLE;
      default:                              w_state_nxt = S_IDLE;
    endcase
  end

  // WB bundle is registered on the accept/ack edge so it is visible during the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu <= '0; r_dst <= '0; r_m2r <= 1'b0; r_rw <= 1'b0; r_store <= 1'b0;
      r_req <= 1'b0; r_we <= 1'b0; r_addr <= '0; r_wdata <= '0;
      r_pcsrc <= 1'b0; r_target <= '0;
      r_wb_valid <= 1'b0; r_wb_rw <= 1'b0; r_wb_dst <= '0; r_wb_data <= '0;
      r_err <= 1'b0;
    end else begin
      r_pcsrc    <= 1'b0;
      r_wb_valid <= 1'b0;
      if (w_accept) begin
        r_alu    <= alu;
        r_dst    <= dst_addr;
        r_m2r    <= mem_to_reg;
        r_rw     <= reg_write;
        r_store  <= mem_write;
        r_pcsrc  <= branch & zero;
        r_target <= pc_branch;
        if (mem_read && mem_write) r_err <= 1'b1;
        if (w_memop) begin
          r_req   <= 1'b1;
          r_we    <= mem_write;
          r_addr  <= alu[ADDR_W-1:0];
          r_wdata <= rt;
        end else begin
          r_wb_valid <= 1'b1;
          r_wb_rw    <= reg_write;
          r_wb_dst   <= dst_addr;
          r_wb_data  <= alu;
        end
      end
      if (w_ack || w_timeout) begin
        r_req      <= 1'b0;
        r_wb_valid <= 1'b1;
        r_wb_dst   <= r_dst;
        if (w_ack) begin
          r_wb_rw   <= r_rw & ~r_store;
          r_wb_data <= r_m2r ? mem_rdata : r_alu;
        end else begin
          r_wb_rw   <= 1'b0;
          r_wb_data <= '0;
          r_err     <= 1'b1;
        end
      end
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign mem_req       = r_req;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign pcsrc         = r_pcsrc;
  assign branch_target = r_target;
  assign wb_valid      = r_wb_valid;
  assign wb_reg_write  = r_wb_rw;
  assign wb_dst_addr   = r_wb_dst;
  assign wb_data       = r_wb_data;
  assign mem_err       = r_err;

endmodule

// File: doc/m_stage.md
Name: m_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Registers the execute-stage bundle (X/M pipeline register) and resolves branches.
- Performs word-addressed data-memory loads and stores over a req/ack handshake, stalling upstream while an access is outstanding.
- Emits a one-cycle-valid writeback bundle to the WB stage.

Parameters:
ADDR_W, 10, data-memory word-address width; mem_addr = alu[ADDR_W-1:0], upper bits ignored
TIMEOUT, 64, ack-wait cycle limit (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  execute-stage bundle valid
in_ready  out  1  stage can accept a bundle this cycle
alu  in  32  ALU result / memory word address
rt  in  32  store data
dst_addr  in  5  destination register
zero  in  1  ALU zero flag
pc_branch  in  32  branch target
branch  in  1  instruction is beq
mem_read  in  1  load
mem_write  in  1  store
mem_to_reg  in  1  WB selects load data
reg_write  in  1  instruction writes register file
mem_req  out  1  memory request
mem_we  out  1  1 = store, 0 = load
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  store data
mem_ack  in  1  request accepted/completed this cycle
mem_rdata  in  32  load data, valid with mem_ack
pcsrc  out  1  take branch (one-cycle pulse)
branch_target  out  32  target valid with pcsrc
wb_valid  out  1  writeback bundle valid (one cycle)
wb_reg_write  out  1  WB register-write enable
wb_dst_addr  out  5  WB destination
wb_data  out  32  load data if mem_to_reg, else ALU result
mem_err  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0 at edge): state IDLE. All outputs 0 except in_ready=1. Pipeline register cleared. Reset mid-access drops the access: mem_req falls next cycle and no wb_valid is issued.
- States:
  - IDLE: in_ready=1.
  - ACCESS: in_ready=0, mem_req=1.
  - RESP: one cycle; emits wb_valid; in_ready=0.
- IDLE, accept (in_valid=1):
  - Bundle captured.
  - No memory op: next cycle wb_valid=1 with wb_data=alu; stay IDLE. Throughput 1/cycle, latency 1.
  - Memory op: go to ACCESS.
- Branch: on accept, pcsrc = branch & zero and branch_target = pc_branch, registered, for exactly one cycle, regardless of memory op.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held constant until mem_ack is sampled high.
  - On ack, go to RESP; load data is captured from mem_rdata.
  - Zero-wait ack (ack in the first ACCESS cycle) is legal.
- RESP: wb_valid=1 for one cycle.
  - Load: wb_data = captured rdata when mem_to_reg=1.
  - Store: wb_reg_write is forced 0.
  - Return to IDLE.
  - Load latency from accept to wb_valid = 2 + wait cycles.
- Writeback bundle: wb_valid cycle only, otherwise wb_valid=0. wb_* hold their last values (no X).
- mem_read & mem_write both set: treated as a store, mem_err set.
- mem_err: sticky until reset.
- Back-to-back: a bundle presented while in_ready=0 is not consumed. Upstream holds it stable.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS.
  - If TIMEOUT cycles pass without mem_ack: mem_req drops, mem_err is set, and a RESP cycle is emitted with wb_reg_write=0 and wb_data=0. Then return to IDLE.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- ALU op alu=0x0000_0005, reg_write=1, dst_addr=3 accepted -> next cycle wb_valid=1, wb_data=5, wb_dst_addr=3; four consecutive ops give four consecutive wb_valid cycles.
- Load, alu=0x0000_0410, ADDR_W=10, ack after 3 cycles with rdata=0xDEADBEEF -> mem_addr=0x010, mem_we=0, in_ready=0 throughout, wb_data=0xDEADBEEF exactly one cycle after ack.
- Store, rt=0x1234_5678, alu=7, zero-wait ack -> mem_we=1, mem_wdata=0x12345678, mem_addr=7, wb_valid=1 with wb_reg_write=0.
- beq, zero=1, pc_branch=0x40 -> pcsrc=1, branch_target=0x40 for one cycle; same with zero=0 -> pcsrc stays 0.
- rst_n=0 during ACCESS -> next cycle mem_req=0, in_ready=1, no wb_valid; mem_read & mem_write both set -> store issued, mem_err=1 until reset.
- MEM_TIMEOUT_EN, TIMEOUT=4, no ack -> mem_req falls after 4 cycles, mem_err=1, wb_valid=1 with wb_reg_write=0.
